// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bus shared by the program
// source (master) and the instruction loader (slave).
interface instr_loader_if #(
  parameter int ADDR_W = 6
);
  // Program byte stream, little-endian within each 32-bit word
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;

  // Word write port into the instruction memory
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Source side: supplies bytes and observes the memory writes
  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // Loader side: consumes bytes and drives the memory writes
  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive instruction-memory addresses while
// holding the core. A load may be aborted; an oversized word_count raises
// a sticky error and is refused.
module instr_loader #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_word_count,
  input  logic              i_abort,
  output logic              o_core_hold,
  output logic              o_done,
  output logic              o_err,
  instr_loader_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LP_MAX_WORDS = (ADDR_W+1)'(MEM_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_word;
  logic              r_err;

  logic              w_xfer;
  logic              w_cnt_zero;
  logic              w_cnt_over;
  logic [ADDR_W:0]   w_word_nxt;
  logic              w_last;

  // Drop one byte into its lane of the word being assembled.
  function automatic logic [31:0] f_insert_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      default: res[31:24] = b;
    endcase
    return res;
  endfunction

  // byte_ready is a pure state decode, so a transfer needs only byte_valid
  // on top of being in RECV.
  assign w_xfer     = (r_state == S_RECV) && bus.byte_valid;
  assign w_cnt_zero = (i_word_count == '0);
  assign w_cnt_over = (i_word_count > LP_MAX_WORDS);
  assign w_word_nxt = {1'b0, r_word_idx} + (ADDR_W+1)'(1);
  assign w_last     = (w_word_nxt == r_count);

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort outranks a simultaneous byte transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_cnt_zero) begin
            w_state_nxt = S_DONE;
          end else if (!w_cnt_over) begin
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer && (r_byte_idx == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from state; abort may only suppress the write strobe.
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.wr_en      = 1'b0;
    o_core_hold    = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      S_RECV: begin
        bus.byte_ready = 1'b1;
        o_core_hold    = 1'b1;
      end
      S_WRITE: begin
        bus.wr_en   = !i_abort;
        o_core_hold = 1'b1;
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_core_hold = 1'b1;
      end
      default: begin
        o_core_hold = 1'b0;
      end
    endcase
  end

  // Word/byte indices, latched count and word assembly; a legal start
  // rewinds to address 0 and an abort throws away the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_count    <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !w_cnt_over) begin
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_count    <= i_word_count;
          end
        end
        S_RECV: begin
          if (i_abort) begin
            r_byte_idx <= '0;
            r_word     <= '0;
          end else if (w_xfer) begin
            r_word     <= f_insert_lane(r_word, r_byte_idx, bus.byte_data);
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          if (i_abort) begin
            r_byte_idx <= '0;
            r_word     <= '0;
          end else if (!w_last) begin
            r_word_idx <= w_word_nxt[ADDR_W-1:0];
          end
        end
        default: begin
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

  // Sticky error: set by an oversized request, cleared by the next legal one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_err <= w_cnt_over;
    end
  end

  assign bus.wr_addr = r_word_idx;
  assign bus.wr_data = r_word;
  assign o_err       = r_err;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: MEM_WORDS, default 64, number of 32-bit words in the instruction memory being loaded.
REQ-002 Parameter: ADDR_W, default 6, word-address width; MEM_WORDS SHALL be no greater than 2**ADDR_W.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  load request; sampled in IDLE only.
REQ-006 Port: word_count  input  ADDR_W+1  number of words to load; sampled with start.
REQ-007 Port: abort  input  1  cancel the load in progress.
REQ-008 Port: byte_valid  input  1  byte_data holds a valid program byte.
REQ-009 Port: byte_data  input  8  program byte stream, little-endian within each word.
REQ-010 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 Port: wr_en  output  1  instruction-memory word write strobe.
REQ-012 Port: wr_addr  output  ADDR_W  word address for the write (byte address >> 2).
REQ-013 Port: wr_data  output  32  word to write.
REQ-014 Port: core_hold  output  1  holds the core's fetch and PC while memory is being loaded.
REQ-015 Port: done  output  1  one-cycle pulse when the load completes.
REQ-016 Port: err  output  1  sticky error flag, set by an illegal word_count.

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE and DONE, held in registers.
REQ-018 Handshake: a byte transfers only in a cycle where byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 only in RECV; byte_valid is ignored in every other state.
REQ-020 IDLE with start=1 and 1<=word_count<=MEM_WORDS: clear word_idx and byte_idx, latch word_count, go to RECV.
REQ-021 IDLE with start=1 and word_count=0: go directly to DONE with no write.
REQ-022 IDLE with start=1 and word_count>MEM_WORDS: set err=1, stay in IDLE, no write, no done.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 RECV, on each transfer: store byte_data in lane byte_idx (lane 0 = bits 7:0, lane 3 = bits 31:24), then increment byte_idx modulo 4.
REQ-025 RECV, on the transfer that fills lane 3: go to WRITE.
REQ-026 WRITE lasts exactly one cycle with wr_en=1, wr_addr=word_idx and wr_data=the assembled word.
REQ-027 After WRITE: if word_idx+1 equals the latched count, go to DONE; otherwise increment word_idx and return to RECV.
REQ-028 Latency: wr_en SHALL assert in the cycle immediately after the 4th byte of a word is accepted.
REQ-029 Peak throughput: 4 bytes per 5 cycles.
REQ-030 DONE lasts one cycle with done=1, then the FSM goes to IDLE.
REQ-031 core_hold SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-032 wr_addr SHALL never exceed MEM_WORDS-1; there is no wrap-around.
REQ-033 abort=1 in RECV or WRITE: go to IDLE next cycle and discard the partial word.
REQ-034 abort has priority over a simultaneous byte transfer, and abort in WRITE forces wr_en=0 that cycle.
REQ-035 An aborted load SHALL produce no done pulse.
REQ-036 abort SHALL be ignored in IDLE and DONE.
REQ-037 err clears only on reset or on the next legal start.
REQ-038 wr_en, done, byte_ready and core_hold SHALL be decoded from state only, with no combinational path from byte_valid; abort's effect on wr_en is the sole exception.

Reset
REQ-039 rst_n=0 SHALL immediately force state=IDLE.
REQ-040 During reset, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=0, done=0, err=0, and word_idx and byte_idx=0.
REQ-041 Reset asserted mid-load SHALL abandon the load with no further write and no done pulse.
REQ-042 Reset deassertion has no other side effects; the first start is accepted on the first clock edge after rst_n rises.

Verification
REQ-043 start, word_count=2, bytes 13,00,00,00,93,00,10,00 sent back-to-back -> two writes: addr0=0x00000013, then addr1=0x00100093; done 1 cycle after the 2nd write; core_hold high from the cycle after start through the DONE cycle.
REQ-044 byte_valid toggled 1/0 pseudo-randomly during a 3-word load -> the same words are written, and wr_en is never asserted while byte_idx!=0.
REQ-045 start with word_count=0 -> done pulses next cycle, no wr_en; start with word_count=65 -> err=1, state stays IDLE, core_hold=0.
REQ-046 abort after the 2nd byte of word 1 in a 4-word load -> only addr0 is written, no done, IDLE next cycle; a new load then starts cleanly at addr0.
REQ-047 rst_n pulsed low while in WRITE -> wr_en drops immediately, all outputs go to reset values, and no done follows.
REQ-048 Full 64-word load -> last write is at addr 63, done follows, and wr_addr never exceeds 63.
